// File: rtl/vga_pkg.sv
// Shared definitions for the VGA plot scheduler: screen defaults, colour layout and FSM states.
package vga_pkg;

    localparam int X_MAX_DEFAULT = 160;
    localparam int Y_MAX_DEFAULT = 120;
    localparam int COLOUR_W      = 24;

    // Colour is packed {R,G,B}, one byte per channel.
    localparam int R_HI = 23;
    localparam int R_LO = 16;
    localparam int G_HI = 15;
    localparam int G_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic logic [7:0] red_of(input logic [COLOUR_W-1:0] colour);
        return colour[R_HI:R_LO];
    endfunction

    function automatic logic [7:0] green_of(input logic [COLOUR_W-1:0] colour);
        return colour[G_HI:G_LO];
    endfunction

    function automatic logic [7:0] blue_of(input logic [COLOUR_W-1:0] colour);
        return colour[B_HI:B_LO];
    endfunction

endpackage

// File: rtl/vga_plot_scheduler_if.sv
// Valid/ready pixel-write channel from a drawing unit into the plot scheduler.
interface vga_plot_scheduler_if;
    import vga_pkg::*;

    logic                valid;
    logic                ready;
    logic [7:0]          x;
    logic [7:0]          y;
    logic [COLOUR_W-1:0] colour;

    modport master (output valid, output x, output y, output colour, input ready);
    modport slave  (input valid, input x, input y, input colour, output ready);

endinterface

// File: rtl/xy_sweep_counter.sv
// Row-major (x,y) sweep over an X_MAX by Y_MAX screen; last flags the final pixel.
module xy_sweep_counter #(
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       step,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       last
);

    localparam logic [7:0] X_END = 8'(X_MAX - 1);
    localparam logic [7:0] Y_END = 8'(Y_MAX - 1);

    // Terminal compares come before any increment so a 256-wide screen never overflows.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x <= 8'd0;
            y <= 8'd0;
        end else if (start) begin
            x <= 8'd0;
            y <= 8'd0;
        end else if (step) begin
            if (x == X_END) begin
                x <= 8'd0;
                if (y == Y_END) begin
                    y <= 8'd0;
                end else begin
                    y <= y + 8'd1;
                end
            end else begin
                x <= x + 8'd1;
            end
        end
    end

    assign last = (x == X_END) && (y == Y_END);

endmodule

// File: rtl/vga_plot_scheduler.sv
// Arbitrates the single VGA pixel-write port between two requesters and a full-screen clear engine.
module vga_plot_scheduler
    import vga_pkg::*;
#(
    parameter int X_MAX = X_MAX_DEFAULT,
    parameter int Y_MAX = Y_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                clear_start,
    input  logic [COLOUR_W-1:0] clear_colour,
    output logic                clear_busy,
    output logic                clear_done,
    vga_plot_scheduler_if.slave req0,
    vga_plot_scheduler_if.slave req1,
    output logic [7:0]          vga_x_out,
    output logic [7:0]          vga_y_out,
    output logic [7:0]          R_buffer,
    output logic [7:0]          G_buffer,
    output logic [7:0]          B_buffer,
    output logic                plot,
    output logic                oob_drop
);

    state_t              state;
    logic                last_grant;
    logic [COLOUR_W-1:0] latched_colour;

    logic                clear_accept;
    logic                grant0;
    logic                grant1;
    logic [7:0]          pick_x;
    logic [7:0]          pick_y;
    logic [COLOUR_W-1:0] pick_colour;
    logic                in_range;

    logic [7:0]          sweep_x;
    logic [7:0]          sweep_y;
    logic                sweep_last;

    // A pending clear outranks both requesters; ties between requesters go to the one not served last.
    always_comb begin
        clear_accept = 1'b0;
        grant0       = 1'b0;
        grant1       = 1'b0;
        if (state == SERVE) begin
            if (clear_start) begin
                clear_accept = 1'b1;
            end else if (req0.valid && req1.valid) begin
                if (last_grant) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (req0.valid) begin
                grant0 = 1'b1;
            end else if (req1.valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0.ready  = grant0 & resetn;
    assign req1.ready  = grant1 & resetn;

    assign pick_x      = grant1 ? req1.x      : req0.x;
    assign pick_y      = grant1 ? req1.y      : req0.y;
    assign pick_colour = grant1 ? req1.colour : req0.colour;
    assign in_range    = ({1'b0, pick_x} < 9'(X_MAX)) && ({1'b0, pick_y} < 9'(Y_MAX));

    xy_sweep_counter #(
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_sweep (
        .clk    (clk),
        .resetn (resetn),
        .start  (clear_accept),
        .step   (state == CLEAR),
        .x      (sweep_x),
        .y      (sweep_y),
        .last   (sweep_last)
    );

    // Busy covers the final clear plot too, so it drops one cycle after clear_done.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= SERVE;
            last_grant     <= 1'b1;
            latched_colour <= '0;
            vga_x_out      <= 8'd0;
            vga_y_out      <= 8'd0;
            R_buffer       <= 8'd0;
            G_buffer       <= 8'd0;
            B_buffer       <= 8'd0;
            plot           <= 1'b0;
            oob_drop       <= 1'b0;
            clear_busy     <= 1'b0;
            clear_done     <= 1'b0;
        end else begin
            plot       <= 1'b0;
            oob_drop   <= 1'b0;
            clear_done <= 1'b0;
            clear_busy <= clear_accept || (state == CLEAR);
            case (state)
                SERVE: begin
                    if (clear_accept) begin
                        state          <= CLEAR;
                        latched_colour <= clear_colour;
                    end else if (grant0 || grant1) begin
                        last_grant <= grant1;
                        if (in_range) begin
                            vga_x_out <= pick_x;
                            vga_y_out <= pick_y;
                            R_buffer  <= red_of(pick_colour);
                            G_buffer  <= green_of(pick_colour);
                            B_buffer  <= blue_of(pick_colour);
                            plot      <= 1'b1;
                        end else begin
                            oob_drop  <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    vga_x_out <= sweep_x;
                    vga_y_out <= sweep_y;
                    R_buffer  <= red_of(latched_colour);
                    G_buffer  <= green_of(latched_colour);
                    B_buffer  <= blue_of(latched_colour);
                    plot      <= 1'b1;
                    if (sweep_last) begin
                        clear_done <= 1'b1;
                        state      <= SERVE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Bench for vga_plot_scheduler: directed scenarios plus random requester traffic against a pixel-level model.
module tb_vga_plot_scheduler;

    localparam int TX = 160;
    localparam int TY = 120;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clear_start;
    logic [23:0] clear_colour;
    logic        clear_busy;
    logic        clear_done;
    logic [7:0]  vga_x_out;
    logic [7:0]  vga_y_out;
    logic [7:0]  R_buffer;
    logic [7:0]  G_buffer;
    logic [7:0]  B_buffer;
    logic        plot;
    logic        oob_drop;

    int checks = 0;
    int errors = 0;

    vga_plot_scheduler_if req0_bus ();
    vga_plot_scheduler_if req1_bus ();

    vga_plot_scheduler #(
        .X_MAX (TX),
        .Y_MAX (TY)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .req0         (req0_bus),
        .req1         (req1_bus),
        .vga_x_out    (vga_x_out),
        .vga_y_out    (vga_y_out),
        .R_buffer     (R_buffer),
        .G_buffer     (G_buffer),
        .B_buffer     (B_buffer),
        .plot         (plot),
        .oob_drop     (oob_drop)
    );

    always #5 clk = ~clk;

    // Model: a clear is pixel index k = 0..TX*TY-1 mapped to (k % TX, k / TX).
    bit          m_clear;
    int          m_k;
    logic [23:0] m_col;
    bit          m_last;
    bit          m_acc0;
    bit          m_acc1;
    logic [7:0]  e_x;
    logic [7:0]  e_y;
    logic [23:0] e_c;
    bit          e_plot;
    bit          e_oob;
    bit          e_busy;
    bit          e_done;

    function automatic bit g0();
        if (!resetn || m_clear || clear_start) return 1'b0;
        if (req0_bus.valid && req1_bus.valid) return m_last;
        return req0_bus.valid;
    endfunction

    function automatic bit g1();
        if (!resetn || m_clear || clear_start) return 1'b0;
        if (req0_bus.valid && req1_bus.valid) return !m_last;
        return req1_bus.valid && !req0_bus.valid;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_clear <= 1'b0;
            m_k     <= 0;
            m_col   <= '0;
            m_last  <= 1'b1;
            m_acc0  <= 1'b0;
            m_acc1  <= 1'b0;
            e_x     <= '0;
            e_y     <= '0;
            e_c     <= '0;
            e_plot  <= 1'b0;
            e_oob   <= 1'b0;
            e_busy  <= 1'b0;
            e_done  <= 1'b0;
        end else begin
            e_plot <= 1'b0;
            e_oob  <= 1'b0;
            e_done <= 1'b0;
            e_busy <= m_clear || clear_start;
            m_acc0 <= g0();
            m_acc1 <= g1();
            if (m_clear) begin
                e_x    <= 8'(m_k % TX);
                e_y    <= 8'(m_k / TX);
                e_c    <= m_col;
                e_plot <= 1'b1;
                m_k    <= m_k + 1;
                if (m_k == TX * TY - 1) begin
                    e_done  <= 1'b1;
                    m_clear <= 1'b0;
                end
            end else if (clear_start) begin
                m_clear <= 1'b1;
                m_k     <= 0;
                m_col   <= clear_colour;
            end else if (g0() || g1()) begin
                m_last <= g1();
                if (int'(g1() ? req1_bus.x : req0_bus.x) < TX && int'(g1() ? req1_bus.y : req0_bus.y) < TY) begin
                    e_x    <= g1() ? req1_bus.x : req0_bus.x;
                    e_y    <= g1() ? req1_bus.y : req0_bus.y;
                    e_c    <= g1() ? req1_bus.colour : req0_bus.colour;
                    e_plot <= 1'b1;
                end else begin
                    e_oob  <= 1'b1;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered outputs are compared at the falling edge; readys once the new inputs have settled.
    always @(negedge clk) begin
        check_output("x",    32'(vga_x_out), 32'(e_x));
        check_output("y",    32'(vga_y_out), 32'(e_y));
        check_output("rgb",  32'({R_buffer, G_buffer, B_buffer}), 32'(e_c));
        check_output("plot", 32'(plot), 32'(e_plot));
        check_output("oob",  32'(oob_drop), 32'(e_oob));
        check_output("busy", 32'(clear_busy), 32'(e_busy));
        check_output("done", 32'(clear_done), 32'(e_done));
        #3;
        check_output("ready0", 32'(req0_bus.ready), 32'(g0()));
        check_output("ready1", 32'(req1_bus.ready), 32'(g1()));
    end

    task automatic apply_stimulus(input bit cs, input logic [23:0] cc,
                                  input bit v0, input logic [7:0] x0, input logic [7:0] y0, input logic [23:0] c0,
                                  input bit v1, input logic [7:0] x1, input logic [7:0] y1, input logic [23:0] c1);
        @(negedge clk);
        #2;
        clear_start     = cs;
        clear_colour    = cc;
        req0_bus.valid  = v0;
        req0_bus.x      = x0;
        req0_bus.y      = y0;
        req0_bus.colour = c0;
        req1_bus.valid  = v1;
        req1_bus.x      = x1;
        req1_bus.y      = y1;
        req1_bus.colour = c1;
    endtask

    initial begin
        int  busy_plots;
        int  done_cnt;
        int  n;
        bit  acc0_seen;
        bit  acc1_seen;
        bit  early;
        bit  done_r1;
        bit  finished;
        bit  done_seen;

        resetn = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        check_output("reset_plot",   32'(plot), 0);
        check_output("reset_x",      32'(vga_x_out), 0);
        check_output("reset_busy",   32'(clear_busy), 0);
        check_output("reset_ready0", 32'(req0_bus.ready), 0);
        check_output("reset_ready1", 32'(req1_bus.ready), 0);
        @(negedge clk);
        #2;
        resetn = 1'b1;

        // Round robin: req0 first after reset, then alternating.
        apply_stimulus(0, 0, 1, 8'd1, 8'd1, 24'h010101, 1, 8'd3, 8'd3, 24'h030303);
        #1;
        check_output("rr1_ready0", 32'(req0_bus.ready), 1);
        check_output("rr1_ready1", 32'(req1_bus.ready), 0);
        apply_stimulus(0, 0, 1, 8'd2, 8'd2, 24'h020202, 1, 8'd3, 8'd3, 24'h030303);
        #1;
        check_output("rr2_ready1", 32'(req1_bus.ready), 1);
        check_output("rr1_x", 32'(vga_x_out), 1);
        apply_stimulus(0, 0, 1, 8'd2, 8'd2, 24'h020202, 1, 8'd4, 8'd4, 24'h040404);
        #1;
        check_output("rr3_ready0", 32'(req0_bus.ready), 1);
        check_output("rr2_x", 32'(vga_x_out), 3);
        apply_stimulus(0, 0, 1, 8'd5, 8'd5, 24'h050505, 1, 8'd4, 8'd4, 24'h040404);
        #1;
        check_output("rr4_ready1", 32'(req1_bus.ready), 1);
        check_output("rr4_ready0", 32'(req0_bus.ready), 0);
        check_output("rr3_x", 32'(vga_x_out), 2);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_output("rr4_x", 32'(vga_x_out), 4);
        check_output("rr4_plot", 32'(plot), 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_output("idle_plot", 32'(plot), 0);
        check_output("idle_hold_x", 32'(vga_x_out), 4);

        apply_stimulus(0, 0, 1, 8'd10, 8'd20, 24'hFF0000, 0, 0, 0, 0);
        #1;
        check_output("px_ready0", 32'(req0_bus.ready), 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_output("px_x", 32'(vga_x_out), 10);
        check_output("px_y", 32'(vga_y_out), 20);
        check_output("px_rgb", 32'({R_buffer, G_buffer, B_buffer}), 32'h00FF0000);
        check_output("px_plot", 32'(plot), 1);

        apply_stimulus(0, 0, 1, 8'd160, 8'd5, 24'h112233, 0, 0, 0, 0);
        #1;
        check_output("oob_ready0", 32'(req0_bus.ready), 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_output("oob_plot", 32'(plot), 0);
        check_output("oob_pulse", 32'(oob_drop), 1);
        check_output("oob_hold_x", 32'(vga_x_out), 10);

        // Full clear colliding with req0, a second clear_start mid-sweep, and req1 arriving mid-sweep.
        apply_stimulus(1, 24'h00FF00, 1, 8'd30, 8'd40, 24'h0000FF, 0, 0, 0, 0);
        #1;
        check_output("clear_beats_req0", 32'(req0_bus.ready), 0);
        busy_plots = 0; done_cnt = 0; acc0_seen = 0; acc1_seen = 0;
        early = 0; done_r1 = 0; finished = 0;
        for (int cyc = 0; cyc < TX * TY + 400; cyc++) begin
            @(negedge clk);
            #1;
            acc0_seen |= m_acc0;
            acc1_seen |= m_acc1;
            if (clear_busy && plot) busy_plots++;
            if (clear_done) begin
                done_cnt++;
                done_r1 = req1_bus.ready;
            end
            if (clear_busy && !clear_done && (req0_bus.ready || req1_bus.ready)) early = 1;
            if (cyc == 150) check_output("sweep_colour_kept", 32'({R_buffer, G_buffer, B_buffer}), 32'h0000FF00);
            if (acc0_seen && acc1_seen) begin
                finished = 1;
                break;
            end
            #1;
            clear_start     = (cyc == 100);
            clear_colour    = (cyc == 100) ? 24'hFFFFFF : 24'h000000;
            req0_bus.valid  = !acc0_seen;
            req1_bus.valid  = (cyc >= 200) && !acc1_seen;
            req1_bus.x      = 8'd50;
            req1_bus.y      = 8'd60;
            req1_bus.colour = 24'h00AA55;
        end
        check_output("clear_completed", 32'(finished), 1);
        check_output("clear_plot_count", 32'(busy_plots), 32'(TX * TY));
        check_output("clear_done_count", 32'(done_cnt), 1);
        check_output("req1_ready_after_clear", 32'(done_r1), 1);
        check_output("no_grant_during_clear", 32'(early), 0);

        // Random requester traffic; data is held while a request waits.
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            #2;
            if (!req0_bus.valid || m_acc0) begin
                req0_bus.valid  = ($urandom_range(0, 3) != 0);
                req0_bus.x      = ($urandom_range(0, 9) == 0) ? 8'(TX + int'($urandom_range(0, 3))) : 8'($urandom_range(0, TX - 1));
                req0_bus.y      = ($urandom_range(0, 9) == 0) ? 8'(TY + int'($urandom_range(0, 3))) : 8'($urandom_range(0, TY - 1));
                req0_bus.colour = 24'($urandom);
            end
            if (!req1_bus.valid || m_acc1) begin
                req1_bus.valid  = ($urandom_range(0, 3) != 0);
                req1_bus.x      = ($urandom_range(0, 9) == 0) ? 8'(TX + int'($urandom_range(0, 3))) : 8'($urandom_range(0, TX - 1));
                req1_bus.y      = ($urandom_range(0, 9) == 0) ? 8'(TY + int'($urandom_range(0, 3))) : 8'($urandom_range(0, TY - 1));
                req1_bus.colour = 24'($urandom);
            end
        end

        // Reset lands on the fifth clear plot.
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 24'h123456, 0, 0, 0, 0, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 50 && n < 5; i++) begin
            @(negedge clk);
            #1;
            clear_start = 1'b0;
            if (plot && clear_busy) n++;
        end
        check_output("reached_plot5", 32'(n), 5);
        #1;
        resetn = 1'b0;
        #1;
        check_output("abort_plot", 32'(plot), 0);
        check_output("abort_x", 32'(vga_x_out), 0);
        check_output("abort_rgb", 32'({R_buffer, G_buffer, B_buffer}), 0);
        check_output("abort_busy", 32'(clear_busy), 0);
        check_output("abort_done", 32'(clear_done), 0);
        repeat (3) @(negedge clk);
        #2;
        resetn = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (clear_done || clear_busy) done_seen = 1;
        end
        check_output("no_done_after_abort", 32'(done_seen), 0);
        apply_stimulus(0, 0, 1, 8'd7, 8'd8, 24'hABCDEF, 0, 0, 0, 0);
        #1;
        check_output("post_reset_ready0", 32'(req0_bus.ready), 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_output("post_reset_x", 32'(vga_x_out), 7);
        check_output("post_reset_y", 32'(vga_y_out), 8);
        check_output("post_reset_rgb", 32'({R_buffer, G_buffer, B_buffer}), 32'h00ABCDEF);
        check_output("post_reset_plot", 32'(plot), 1);

        repeat (2) @(negedge clk);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
